// File: rtl/nic_pkg.sv
// rtl/nic_pkg.sv - register map and packet field layout shared by the nic slice
package nic_pkg;

  typedef enum logic [1:0] {
    NIC_IN_BUF   = 2'b00,
    NIC_IN_STAT  = 2'b01,
    NIC_OUT_BUF  = 2'b10,
    NIC_OUT_STAT = 2'b11
  } nicReg;

  // Packet fields, MSB-first numbering
  localparam int VC_BIT        = 0;
  localparam int DIR_BIT       = 1;
  localparam int HOP_FIRST     = 8;
  localparam int HOP_LAST      = 15;
  localparam int SRC_FIRST     = 16;
  localparam int SRC_LAST      = 31;
  localparam int PAYLOAD_FIRST = 32;
  localparam int PAYLOAD_LAST  = 63;

  typedef logic [0:63] nicPacket;

  function automatic logic vcOf(nicPacket pkt);
    return pkt[VC_BIT];
  endfunction

endpackage

// File: rtl/nic_if.sv
// rtl/nic_if.sv - cpu register port and ring router port of the nic
interface nic_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 2
);
  logic [0:ADDR_WIDTH-1] nicAddr;
  logic [0:DATA_WIDTH-1] nicDataIn;
  logic [0:DATA_WIDTH-1] nicDataOut;
  logic                  nicEn;
  logic                  nicWrEn;
  logic                  net_so;
  logic                  net_ro;
  logic [0:DATA_WIDTH-1] net_do;
  logic                  net_polarity;
  logic                  net_si;
  logic                  net_ri;
  logic [0:DATA_WIDTH-1] net_di;

  modport slave (
    input  nicAddr, nicDataIn, nicEn, nicWrEn,
    input  net_ro, net_polarity, net_si, net_di,
    output nicDataOut, net_so, net_do, net_ri
  );

  modport master (
    output nicAddr, nicDataIn, nicEn, nicWrEn,
    output net_ro, net_polarity, net_si, net_di,
    input  nicDataOut, net_so, net_do, net_ri
  );
endinterface

// File: rtl/nic_buffer.sv
// rtl/nic_buffer.sv - one-entry packet register with full flag
module nic_buffer #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             clear,
  input  logic [0:WIDTH-1] loadData,
  output logic [0:WIDTH-1] data,
  output logic             full
);

  // Load wins over clear; data is kept on clear so stale reads return the last packet
  always_ff @(posedge clk) begin
    if (reset) begin
      data <= '0;
      full <= 1'b0;
    end else if (load) begin
      data <= loadData;
      full <= 1'b1;
    end else if (clear) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/nic.sv
// rtl/nic.sv - network interface controller: cpu register file over two one-entry ring buffers
module nic
  import nic_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 2
) (
  input logic  clk,
  input logic  reset,
  nic_if.slave bus
);

  logic [0:DATA_WIDTH-1] outBuf;
  logic [0:DATA_WIDTH-1] inBuf;
  logic                  outFull;
  logic                  inFull;
  logic                  cpuRead;
  logic                  cpuWrite;
  logic                  outLoad;
  logic                  inject;
  logic                  inLoad;
  logic                  inClear;
  nicReg                 regSel;

  assign regSel   = nicReg'(bus.nicAddr);
  assign cpuRead  = bus.nicEn & ~bus.nicWrEn;
  assign cpuWrite = bus.nicEn & bus.nicWrEn;

  // Injection is held off while reset is asserted so nothing leaves in the reset cycle
  assign inject  = outFull & bus.net_ro & (bus.net_polarity == vcOf(outBuf)) & ~reset;
  assign outLoad = cpuWrite & (regSel == NIC_OUT_BUF) & ~outFull;

  assign inLoad  = bus.net_si & ~inFull;
  assign inClear = cpuRead & (regSel == NIC_IN_BUF) & inFull;

  nic_buffer #(.WIDTH(DATA_WIDTH)) outBuffer (
    .clk      (clk),
    .reset    (reset),
    .load     (outLoad),
    .clear    (inject),
    .loadData (bus.nicDataIn),
    .data     (outBuf),
    .full     (outFull)
  );

  nic_buffer #(.WIDTH(DATA_WIDTH)) inBuffer (
    .clk      (clk),
    .reset    (reset),
    .load     (inLoad),
    .clear    (inClear),
    .loadData (bus.net_di),
    .data     (inBuf),
    .full     (inFull)
  );

  assign bus.net_so = inject;
  assign bus.net_do = outFull ? outBuf : '0;
  assign bus.net_ri = ~inFull;

  always_comb begin
    bus.nicDataOut = '0;
    if (cpuRead) begin
      unique case (regSel)
        NIC_IN_BUF:   bus.nicDataOut = inBuf;
        NIC_IN_STAT:  bus.nicDataOut[DATA_WIDTH-1] = inFull;
        NIC_OUT_BUF:  bus.nicDataOut = outBuf;
        NIC_OUT_STAT: bus.nicDataOut[DATA_WIDTH-1] = outFull;
        default:      bus.nicDataOut = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_nic.sv
// tb/tb_nic.sv - scoreboard bench for nic: directed scenarios then randomized traffic
module tb_nic;

  typedef logic [0:63] pktT;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  nic_if bus ();
  nic dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int  checks = 0;
  int  errors = 0;
  bit  started = 1'b0;
  pktT outQ[$];
  pktT inQ[$];
  pktT injQ[$];
  pktT rdQ[$];
  pktT lastIn = '0;
  pktT lastOut = '0;

  task automatic check(string name, pktT act, pktT exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic pktT expRead(logic [1:0] a);
    case (a)
      2'b00:   return (inQ.size() != 0) ? inQ[0] : lastIn;
      2'b01:   return pktT'(inQ.size() != 0);
      2'b10:   return (outQ.size() != 0) ? outQ[0] : lastOut;
      default: return pktT'(outQ.size() != 0);
    endcase
  endfunction

  // Reference model: each buffer is a queue of at most one packet
  always @(posedge clk) begin
    bit inj, wrOk, rdClr, ejOk;
    if (reset) begin
      started = 1'b1;
      outQ.delete();
      inQ.delete();
      injQ.delete();
      lastIn  = '0;
      lastOut = '0;
    end else begin
      inj   = (outQ.size() != 0) && bus.net_ro && (bus.net_polarity == outQ[0][0]);
      wrOk  = bus.nicEn && bus.nicWrEn && (bus.nicAddr == 2'b10) && (outQ.size() == 0);
      rdClr = bus.nicEn && !bus.nicWrEn && (bus.nicAddr == 2'b00) && (inQ.size() != 0);
      ejOk  = bus.net_si && (inQ.size() == 0);
      if (inj) void'(outQ.pop_front());
      if (wrOk) begin
        outQ.push_back(bus.nicDataIn);
        injQ.push_back(bus.nicDataIn);
        lastOut = bus.nicDataIn;
      end
      if (rdClr) void'(inQ.pop_front());
      if (ejOk) begin
        inQ.push_back(bus.net_di);
        lastIn = bus.net_di;
      end
    end
  end

  always @(negedge clk) begin
    bit expSo;
    if (started) begin
      expSo = !reset && (outQ.size() != 0) && bus.net_ro && (bus.net_polarity == outQ[0][0]);
      check("net_so", pktT'(bus.net_so), pktT'(expSo));
      check("net_ri", pktT'(bus.net_ri), pktT'(inQ.size() == 0));
      check("net_do", bus.net_do, (outQ.size() != 0) ? outQ[0] : '0);
      if (bus.net_so === 1'b1) begin
        if (injQ.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL inject: got %h expected no injection", bus.net_do);
        end else begin
          check("inject", bus.net_do, injQ.pop_front());
        end
      end
      if (bus.nicEn && !bus.nicWrEn) begin
        if (rdQ.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL read: got %h expected no read", bus.nicDataOut);
        end else begin
          check($sformatf("read addr%0d", bus.nicAddr), bus.nicDataOut, rdQ.pop_front());
        end
      end else if (!bus.nicEn) begin
        check("idle read", bus.nicDataOut, '0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    bus.nicEn   = 1'b0;
    bus.nicWrEn = 1'b0;
    bus.net_si  = 1'b0;
  endtask

  task automatic rd(logic [1:0] a);
    bus.nicEn   = 1'b1;
    bus.nicWrEn = 1'b0;
    bus.nicAddr = a;
    rdQ.push_back(expRead(a));
  endtask

  task automatic wr(logic [1:0] a, pktT d);
    bus.nicEn     = 1'b1;
    bus.nicWrEn   = 1'b1;
    bus.nicAddr   = a;
    bus.nicDataIn = d;
  endtask

  task automatic ej(pktT d);
    bus.net_si = 1'b1;
    bus.net_di = d;
  endtask

  initial begin
    reset            = 1'b1;
    bus.nicAddr      = '0;
    bus.nicDataIn    = '0;
    bus.nicEn        = 1'b0;
    bus.nicWrEn      = 1'b0;
    bus.net_ro       = 1'b0;
    bus.net_polarity = 1'b0;
    bus.net_si       = 1'b0;
    bus.net_di       = '0;
    repeat (3) step();
    step(); reset = 1'b0;
    step(); rd(2'b11);
    step(); rd(2'b01);

    // write held by net_ro=0, then a single-cycle injection
    step(); wr(2'b10, 64'h0000_0000_DEAD_BEEF);
    step(); rd(2'b11);
    step(); bus.net_ro = 1'b1; bus.net_polarity = 1'b0;
    step(); rd(2'b11);

    // VC bit 1 waits for matching polarity
    step(); wr(2'b10, 64'h8000_0000_0000_00AA);
    repeat (4) step();
    step(); bus.net_polarity = 1'b1;
    step(); bus.net_polarity = 1'b0;

    // ejection and destructive read
    step(); ej(64'h8000_0000_0000_1234);
    step(); rd(2'b01);
    step(); rd(2'b00);
    step(); rd(2'b01);
    step(); rd(2'b00);

    // second write while full is dropped
    step(); bus.net_ro = 1'b0; wr(2'b10, 64'h0000_0000_0000_0A0A);
    step(); wr(2'b10, 64'h1);
    step(); rd(2'b10);
    step(); bus.net_ro = 1'b1;
    step(); bus.net_ro = 1'b0;

    // write on the injection edge is dropped
    step(); wr(2'b10, 64'h0000_0000_0000_0B0B);
    step(); bus.net_ro = 1'b1; wr(2'b10, 64'h0000_0000_0000_0C0C);
    step(); bus.net_ro = 1'b0; rd(2'b11);

    // reset with both buffers full
    step(); wr(2'b10, 64'h0000_0000_0000_0D0D); ej(64'h0000_0000_0000_0E0E);
    step(); reset = 1'b1;
    step(); reset = 1'b0; rd(2'b11);
    step(); rd(2'b01);

    for (int i = 0; i < 600; i++) begin
      int op;
      pktT d;
      step();
      reset            = ($urandom_range(0, 63) == 0);
      bus.net_ro       = $urandom_range(0, 1);
      bus.net_polarity = $urandom_range(0, 1);
      d = {$urandom, $urandom};
      if ($urandom_range(0, 2) == 0) ej(d);
      d  = {$urandom, $urandom};
      op = $urandom_range(0, 3);
      case (op)
        1:       rd(2'($urandom_range(0, 3)));
        2:       wr(2'b10, d);
        3:       wr(2'($urandom_range(0, 3)), d);
        default: ;
      endcase
    end

    step(); reset = 1'b0; bus.net_ro = 1'b0;
    step();
    @(negedge clk);
    #1;
    check("read queue drained", pktT'(rdQ.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/nic.md
# nic

Network interface controller between a node `cpu` (via its `nicAddr`/`nicDataIn`/`nicDataOut`/`nicEn`/`nicWrEn` port group) and its local ring router port. It holds two one-entry packet buffers:
- an output channel buffer, which the CPU fills and the NIC injects into the router;
- an input channel buffer, which the router fills and the CPU drains.

The CPU sees four 64-bit registers selected by a 2-bit address. Bit numbering is MSB-first (`[0:63]`) throughout.

## Interface
Parameters:
- `DATA_WIDTH`, 64, packet/register width.
- `ADDR_WIDTH`, 2, CPU register-select width.

Ports:
- `clk`  in  1  single clock; all state updates on posedge.
- `reset`  in  1  synchronous, active-high; sampled on posedge.
- `nicAddr`  in  [0:1]  register select: 00 input buffer, 01 input status, 10 output buffer, 11 output status.
- `nicDataIn`  in  [0:63]  CPU write data (driven from cpu `nicDataOut`).
- `nicDataOut`  out  [0:63]  CPU read data (drives cpu `nicDataIn`).
- `nicEn`  in  1  CPU access strobe.
- `nicWrEn`  in  1  1 = write, 0 = read; qualified by `nicEn`.
- `net_so`  out  1  inject valid to router.
- `net_ro`  in  1  router ready to accept injection.
- `net_do`  out  [0:63]  inject packet.
- `net_polarity`  in  1  router's current external polarity.
- `net_si`  in  1  eject valid from router.
- `net_ri`  out  1  NIC ready to accept ejection.
- `net_di`  in  [0:63]  eject packet.

## Operation
State:
- Output buffer: `out_buf[0:63]` and `out_full`.
- Input buffer: `in_buf[0:63]` and `in_full`.

Reset:
- `out_full = 0`, `in_full = 0`, and both buffers cleared to 0.
- Resulting outputs: `net_so = 0`, `net_ri = 1`, `net_do = 0`, `nicDataOut = 0`.

CPU read (`nicEn=1`, `nicWrEn=0`), combinational select:
- Addr 00: `in_buf`. If `in_full = 1`, clear `in_full` at the next edge (destructive read). A read while `in_full = 0` returns the stale `in_buf` and has no side effect.
- Addr 01: `{63'b0, in_full}`, i.e. the flag is in bit 63.
- Addr 10: `out_buf`, no side effect.
- Addr 11: `{63'b0, out_full}`.
- With `nicEn = 0`: `nicDataOut = 0`.

CPU write (`nicEn=1`, `nicWrEn=1`):
- Addr 10 with `out_full = 0` (pre-edge value): load `out_buf <= nicDataIn`, set `out_full`.
- Addr 10 with `out_full = 1`: write silently dropped; the buffer is unchanged.
- Writes to 00, 01 and 11 are ignored.

Injection:
- `net_so = out_full & net_ro & (net_polarity == out_buf[0])`, where bit 0 is the packet VC bit.
- `net_do = out_buf` whenever `out_full = 1`, else 0.
- On an edge where `net_so = 1`, `out_full` clears.

Ejection:
- `net_ri = ~in_full`.
- On an edge where `net_si & net_ri`, load `in_buf <= net_di` and set `in_full`.
- `net_si` while `in_full = 1` is a router protocol violation; the NIC ignores it and `in_buf` is unchanged.

Simultaneous events:
- Injection and a CPU write to 10 on the same edge: the write sees pre-edge `out_full = 1` and is dropped. The CPU must re-poll status 11.
- A CPU destructive read of 00 and router ejection cannot coincide, because `net_ri = 0` while full.

## Timing
- CPU read data: zero latency (combinational from address and state).
- Status change visibility: the cycle after the causing edge.
- Write to injection: earliest `net_so` is one cycle after the write edge, given `net_ro` and matching polarity.
- Ejection to CPU-visible `in_full = 1`: one cycle.
- Buffer reuse:
  - Output: the minimum write-to-next-accepted-write spacing is 2 cycles (write, inject, write).
  - Input: one ejection per 2 cycles at best (capture, CPU read).
- Reset asserted mid-transfer: both buffers drop their contents at that edge. No `net_so` in the reset cycle or the next.

## Structure
- Package `nic_pkg` holds:
  - address constants `NIC_IN_BUF=2'b00`, `NIC_IN_STAT=2'b01`, `NIC_OUT_BUF=2'b10`, `NIC_OUT_STAT=2'b11`;
  - packet field positions: VC bit 0, direction bit 1, hop field [8:15], source field [16:31], payload [32:63].
- Sub-module `nic_buffer` is instantiated twice. It is a one-entry register plus full flag with `load`/`clear` inputs and `data`/`full` outputs, and resolves load and clear per edge.

## Test plan
- Reset for 3 cycles, then idle → `net_ri=1`, `net_so=0`, read 11 returns 0, read 01 returns 0.
- Write `64'h0000_0000_DEAD_BEEF` to 10 with `net_ro=0` → read 11 = 1. Then set `net_ro=1`, `net_polarity=0` → `net_so=1` for exactly one cycle with `net_do=64'h0000_0000_DEAD_BEEF`, and read 11 = 0 afterwards.
- Packet with bit 0 = 1, `net_ro=1`, `net_polarity=0` for 4 cycles → `net_so` stays 0. Flip polarity to 1 → inject on that cycle.
- Router drives `net_si=1`, `net_di=64'h8000_0000_0000_1234` → next cycle `net_ri=0` and read 01 = 1. A read of 00 returns the packet; the following cycle `in_full=0` and `net_ri=1`.
- Second write to 10 while full, with the value `64'h1` → dropped; the injected packet is still the first value.
- Same-edge injection and CPU write to 10 → the write is dropped and `out_full=0` afterwards. Also assert reset while both buffers are full → both flags are 0 next cycle.
